// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: IDLE/RUN/DONE sequencer that steps the
// PC (increment, absolute or relative branch), and keeps saturating cycle and
// retired-instruction counters for the current or last run.
module pc_fetch_ctrl #(
  parameter int PC_WIDTH   = 10,
  parameter int OFF_WIDTH  = 8,
  parameter int START_ADDR = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt_req,
  input  logic                 branch_en,
  input  logic                 branch_rel,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic [OFF_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_en,
  output logic                 busy,
  output logic                 halt,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_START = PC_WIDTH'(START_ADDR);

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] pc_next_run;

  // Sign-extend (or truncate) the relative offset to PC width.
  always_comb begin
    off_ext = PC_WIDTH'($signed(branch_offset));
  end

  // Next PC while running and neither halting nor stalled.
  always_comb begin
    pc_next_run = pc + PC_WIDTH'(1);
    if (branch_en) begin
      pc_next_run = branch_rel ? (pc + off_ext) : branch_target;
    end
  end

  // Run status decoded from the registered state only.
  always_comb begin
    busy     = (state == RUN);
    halt     = (state == DONE);
    fetch_en = busy & ~stall;
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= PC_START;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            pc          <= PC_START;
            cycle_count <= '0;
            instr_count <= '0;
          end
        end
        RUN: begin
          if (cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
          end
          // A halting instruction retires even when stalled.
          if ((halt_req || !stall) && (instr_count != '1)) begin
            instr_count <= instr_count + CNT_WIDTH'(1);
          end
          if (halt_req) begin
            state <= DONE;
          end else if (!stall) begin
            pc <= pc_next_run;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a default instance plus a CNT_WIDTH=4
// instance share stimulus; a reference model pushes expected post-edge state
// which is popped and compared after each rising edge.
module tb_pc_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, halt_req, branch_en, branch_rel;
  logic [9:0] branch_target;
  logic [7:0] branch_offset;

  logic [9:0]  pc, pc4;
  logic        fetch_en, busy, halt, fetch_en4, busy4, halt4;
  logic [15:0] cycle_count, instr_count;
  logic [3:0]  cycle_count4, instr_count4;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  typedef struct {
    logic [9:0]  pc;
    logic        busy;
    logic        halt;
    logic [15:0] cc;
    logic [15:0] ic;
    logic [3:0]  cc4;
    logic [3:0]  ic4;
  } exp_t;

  exp_t sb[$];

  // reference model state: 0 idle, 1 run, 2 done
  int m_st, m_pc, m_cc, m_ic, m_cc4, m_ic4;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.PC_WIDTH(10), .OFF_WIDTH(8), .START_ADDR(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_en(branch_en), .branch_rel(branch_rel), .branch_target(branch_target),
    .branch_offset(branch_offset), .pc(pc), .fetch_en(fetch_en), .busy(busy),
    .halt(halt), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  pc_fetch_ctrl #(.PC_WIDTH(10), .OFF_WIDTH(8), .START_ADDR(0), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_en(branch_en), .branch_rel(branch_rel), .branch_target(branch_target),
    .branch_offset(branch_offset), .pc(pc4), .fetch_en(fetch_en4), .busy(busy4),
    .halt(halt4), .cycle_count(cycle_count4), .instr_count(instr_count4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_cc = 0; m_ic = 0; m_cc4 = 0; m_ic4 = 0;
  endtask

  task automatic check_now(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".pc4"}, 32'(pc4), 32'(m_pc));
    chk({tag, ".busy"}, 32'(busy), 32'(m_st == 1));
    chk({tag, ".halt"}, 32'(halt), 32'(m_st == 2));
    chk({tag, ".fetch_en"}, 32'(fetch_en), 32'((m_st == 1) && !stall));
    chk({tag, ".cc"}, 32'(cycle_count), 32'(m_cc));
    chk({tag, ".ic"}, 32'(instr_count), 32'(m_ic));
    chk({tag, ".cc4"}, 32'(cycle_count4), 32'(m_cc4));
    chk({tag, ".ic4"}, 32'(instr_count4), 32'(m_ic4));
  endtask

  // One clock: drive at the falling edge, predict, compare after the rising edge.
  task automatic cyc(input string tag, input logic s, input logic st, input logic h,
                     input logic be, input logic br, input logic [9:0] tgt,
                     input logic [7:0] off);
    int o;
    exp_t e;
    exp_t got;
    start = s; stall = st; halt_req = h; branch_en = be; branch_rel = br;
    branch_target = tgt; branch_offset = off;
    #1;
    chk({tag, ".fetch_en"}, 32'(fetch_en), 32'((m_st == 1) && !st));
    chk({tag, ".fetch_en4"}, 32'(fetch_en4), 32'((m_st == 1) && !st));
    if (m_st == 0) begin
      if (s) begin
        m_st = 1; m_pc = 0; m_cc = 0; m_ic = 0; m_cc4 = 0; m_ic4 = 0;
      end
    end else if (m_st == 1) begin
      m_cc  = (m_cc  < 65535) ? m_cc + 1  : m_cc;
      m_cc4 = (m_cc4 < 15)    ? m_cc4 + 1 : m_cc4;
      if (h || !st) begin
        m_ic  = (m_ic  < 65535) ? m_ic + 1  : m_ic;
        m_ic4 = (m_ic4 < 15)    ? m_ic4 + 1 : m_ic4;
      end
      if (h) m_st = 2;
      else if (!st) begin
        if (be && br) begin
          o = int'(off);
          if (off[7]) o = o - 256;
          m_pc = (m_pc + o + 1024) % 1024;
        end else if (be) m_pc = int'(tgt);
        else m_pc = (m_pc + 1) % 1024;
      end
    end else begin
      if (!s) m_st = 0;
    end
    e.pc = 10'(m_pc); e.busy = (m_st == 1); e.halt = (m_st == 2);
    e.cc = 16'(m_cc); e.ic = 16'(m_ic); e.cc4 = 4'(m_cc4); e.ic4 = 4'(m_ic4);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({tag, ".pc"}, 32'(pc), 32'(got.pc));
      chk({tag, ".pc4"}, 32'(pc4), 32'(got.pc));
      chk({tag, ".busy"}, 32'(busy), 32'(got.busy));
      chk({tag, ".halt"}, 32'(halt), 32'(got.halt));
      chk({tag, ".busy4"}, 32'(busy4), 32'(got.busy));
      chk({tag, ".halt4"}, 32'(halt4), 32'(got.halt));
      chk({tag, ".cc"}, 32'(cycle_count), 32'(got.cc));
      chk({tag, ".ic"}, 32'(instr_count), 32'(got.ic));
      chk({tag, ".cc4"}, 32'(cycle_count4), 32'(got.cc4));
      chk({tag, ".ic4"}, 32'(instr_count4), 32'(got.ic4));
    end
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit expired");
    nerr++;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; halt_req = 0; branch_en = 0; branch_rel = 0;
    branch_target = '0; branch_offset = '0;
    model_reset();
    #2;
    check_now("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic run: halt on 6th RUN cycle -> pc 0..5, counts 6
    cyc("go", 1, 0, 0, 0, 0, 10'd0, 8'd0);
    for (int unsigned i = 0; i < 5; i++) cyc("inc", 1, 0, 0, 0, 0, 10'd0, 8'd0);
    cyc("halt6", 1, 0, 1, 0, 0, 10'd0, 8'd0);
    chk("run1.final_pc", 32'(pc), 32'd5);
    chk("run1.final_cc", 32'(cycle_count), 32'd6);
    chk("run1.final_ic", 32'(instr_count), 32'd6);
    cyc("done_hold", 1, 0, 0, 0, 0, 10'd0, 8'd0);
    cyc("to_idle", 0, 0, 0, 1, 0, 10'd99, 8'd0);
    cyc("idle_nobr", 0, 0, 0, 1, 0, 10'd99, 8'd0);

    // branches, wraps, stall
    cyc("go2", 1, 0, 0, 0, 0, 10'd0, 8'd0);
    cyc("abs20", 1, 0, 0, 1, 0, 10'd20, 8'd0);
    cyc("rel_m5", 0, 0, 0, 1, 1, 10'd0, 8'hFB);
    chk("rel_m5.pc15", 32'(pc), 32'd15);
    cyc("abs3", 0, 0, 0, 1, 0, 10'd3, 8'd0);
    cyc("rel_wrap", 0, 0, 0, 1, 1, 10'd0, 8'hFB);
    chk("rel_wrap.pc1022", 32'(pc), 32'd1022);
    cyc("inc1023", 0, 0, 0, 0, 0, 10'd0, 8'd0);
    cyc("wrap0", 0, 0, 0, 0, 0, 10'd0, 8'd0);
    chk("wrap0.pc", 32'(pc), 32'd0);
    cyc("abs155", 0, 0, 0, 1, 0, 10'h155, 8'd0);
    chk("abs155.pc", 32'(pc), 32'h155);
    cyc("rel_pos", 0, 0, 0, 1, 1, 10'd0, 8'h7F);
    cyc("abs7", 0, 0, 0, 1, 0, 10'd7, 8'd0);
    cyc("stall_br", 0, 1, 0, 1, 0, 10'd300, 8'd0);
    chk("stall_br.pc7", 32'(pc), 32'd7);
    cyc("stall_halt", 0, 1, 1, 1, 0, 10'd300, 8'd0);
    cyc("done_pc", 0, 0, 0, 1, 0, 10'd300, 8'd0);

    // saturation of the 4-bit counters
    cyc("go3", 1, 0, 0, 0, 0, 10'd0, 8'd0);
    for (int unsigned i = 0; i < 19; i++)
      cyc("sat", 1, (i % 4) == 1, 0, 0, 0, 10'd0, 8'd0);
    cyc("sat_halt", 1, 0, 1, 0, 0, 10'd0, 8'd0);
    chk("sat.cc4", 32'(cycle_count4), 32'd15);
    chk("sat.cc16", 32'(cycle_count), 32'd20);
    cyc("sat_hold", 0, 0, 0, 0, 0, 10'd0, 8'd0);

    // asynchronous reset mid-run
    cyc("go4", 1, 0, 0, 0, 0, 10'd0, 8'd0);
    cyc("r_inc", 1, 0, 0, 1, 0, 10'd40, 8'd0);
    cyc("r_inc2", 1, 0, 0, 0, 0, 10'd0, 8'd0);
    #2;
    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; halt_req = 1'b0; branch_en = 1'b0;
    #1;
    model_reset();
    check_now("midrst");
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cyc("post_idle", 0, 0, 0, 0, 0, 10'd0, 8'd0);
    cyc("restart", 1, 0, 0, 0, 0, 10'd0, 8'd0);
    chk("restart.pc", 32'(pc), 32'd0);
    cyc("restart_inc", 1, 0, 0, 0, 0, 10'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
